// File: rtl/mem_access_stage.sv
// MEM-stage data memory: word loads/stores with a fixed multi-cycle latency,
// pipeline stall generation, and register-write gating for the MEM/WB register.
module mem_access_stage #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  output logic [31:0] mdo,
  output logic        mstall,
  output logic        mwreg_g,
  output logic        maddr_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_count;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_mdo;
  logic                r_addr_err;

  logic                w_access;
  logic                w_aligned;
  logic                w_req;
  logic                w_misalign;
  logic                w_complete;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_unused_hi;

  assign w_access   = mm2reg | mwmem;
  assign w_aligned  = (mr[1:0] == 2'b00);
  // Gated by resetn so a held request cannot raise mstall or commit while in reset.
  assign w_req      = resetn & w_access & w_aligned;
  assign w_misalign = w_access & ~w_aligned;
  assign w_idx      = mr[ADDR_W+1:2];
  assign w_unused_hi = ^mr[31:ADDR_W+2];

  assign w_complete = ((r_state == BUSY) && (r_count == 4'd1)) ||
                      ((LATENCY == 1) && (r_state == IDLE) && w_req);

  assign mstall    = ((r_state == IDLE) && w_req) || (r_state == BUSY);
  assign mwreg_g   = mwreg & ~mstall;
  assign mdo       = r_mdo;
  assign maddr_err = r_addr_err;

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_complete)  w_next = DONE;
        else if (w_req)  w_next = BUSY;
      end
      BUSY: if (w_complete) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_mdo      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_req) begin
        r_count <= 4'(LATENCY - 1);
      end else if (r_state == BUSY) begin
        r_count <= r_count - 4'd1;
      end
      if ((r_state == IDLE) && w_misalign) begin
        r_mdo      <= '0;
        r_addr_err <= 1'b1;
      end else if (w_complete) begin
        if (mwmem && mm2reg) r_mdo <= '0;
        else if (mm2reg)     r_mdo <= r_mem[w_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive resetn, and only the
  // completion edge of a store writes it, so an aborted store leaves it untouched.
  always_ff @(posedge clock) begin
    if (w_complete && mwmem) begin
      r_mem[w_idx] <= mqb;
    end
  end

endmodule
